// File: rtl/csr_pkg.sv
// Shared CSR address map, write-op encodings, interrupt bit positions and the
// address decoder used by every read/write port of csr_bank.
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_W    = 2'b01,
        OP_S    = 2'b10,
        OP_C    = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;

    localparam logic [3:0] CNT_BANK_M = 4'hB;
    localparam logic [3:0] CNT_BANK_U = 4'hC;

    localparam int unsigned MSTATUS_MIE = 3;
    localparam int unsigned MIP_MSIP    = 3;
    localparam int unsigned MIP_MTIP    = 7;
    localparam int unsigned MIP_MEIP    = 11;

    typedef struct packed {
        logic       impl;
        logic       ro;
        logic       is_cnt;
        logic       hi;
        logic [4:0] cidx;  // 0 = cycle, 1 = instret, 2+k = hpm k
    } csr_decode_t;

    function automatic csr_decode_t decode_csr(input logic [11:0] addr,
                                               input int unsigned num_hpm);
        csr_decode_t d;
        logic [4:0]  off;
        d   = '0;
        off = addr[4:0];
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINHIBIT,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: d.impl = 1'b1;
            CSR_MIP: begin
                d.impl = 1'b1;
                d.ro   = 1'b1;
            end
            default: begin
                if ((addr[11:8] == CNT_BANK_M || addr[11:8] == CNT_BANK_U) &&
                    addr[6:5] == 2'b00) begin
                    if (off == 5'd0) begin
                        d.is_cnt = 1'b1;
                        d.cidx   = 5'd0;
                    end else if (off == 5'd2) begin
                        d.is_cnt = 1'b1;
                        d.cidx   = 5'd1;
                    end else if (off >= 5'd3 && {27'd0, off} < 32'd3 + num_hpm) begin
                        d.is_cnt = 1'b1;
                        d.cidx   = off - 5'd1;
                    end
                    if (d.is_cnt) begin
                        d.impl = 1'b1;
                        d.ro   = (addr[11:8] == CNT_BANK_U);
                        d.hi   = addr[7];
                    end
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// One 64-bit performance counter: per-half CSR writes take priority over the
// increment, which is gated by the matching mcountinhibit bit.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_lo_i,
    input  logic [31:0] wdata_hi_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [63:0] cnt_q, cnt_d;

    // NOTE: next state starts as a copy of the register so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) cnt_d[31:0]  = wdata_lo_i;
            if (we_hi_i) cnt_d[63:32] = wdata_hi_i;
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and wins over writes.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = cnt_q[63:32];

endmodule

// File: rtl/csr_bank.sv
// Machine-mode CSR bank with an ex port (W/S/C ops) and a clint port (W only).
// Macro CSR_HPM_EN builds the NUM_HPM hpm counters; undefined leaves them out.
module csr_bank
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NUM_HPM     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_we_i,
    input  logic [1:0]         ex_op_i,
    input  logic [11:0]        ex_raddr_i,
    input  logic [11:0]        ex_waddr_i,
    input  logic [XLEN-1:0]    ex_data_i,
    output logic [XLEN-1:0]    ex_data_o,
    output logic               ex_illegal_o,
    input  logic               clint_we_i,
    input  logic [11:0]        clint_raddr_i,
    input  logic [11:0]        clint_waddr_i,
    input  logic [XLEN-1:0]    clint_data_i,
    output logic [XLEN-1:0]    clint_data_o,
    input  logic               instret_i,
    input  logic [NUM_HPM-1:0] hpm_event_i,
    input  logic               irq_ext_i,
    input  logic               irq_timer_i,
    input  logic               irq_sw_i,
    output logic [XLEN-1:0]    mtvec_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mstatus_o,
    output logic               global_int_en_o,
    output logic               irq_pending_o
);

`ifdef CSR_HPM_EN
    localparam int unsigned HPM_BUILT = NUM_HPM;
`else
    localparam int unsigned HPM_BUILT = 0;
`endif
    localparam int NUM_CNT = 2 + int'(HPM_BUILT);
    localparam logic [XLEN-1:0] CINH_MASK = (HPM_BUILT != 0) ? {XLEN{1'b1}} : XLEN'(7);

    logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mepc_q, mepc_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mcountinhibit_q, mcountinhibit_d, mip_q, mip_d;

    logic [31:0]        cnt_lo [NUM_CNT];
    logic [31:0]        cnt_hi [NUM_CNT];
    logic [31:0]        cnt_wlo [NUM_CNT];
    logic [31:0]        cnt_whi [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_we_lo, cnt_we_hi, cnt_inc, cnt_inh;

    // Lookups: 0 = ex read, 1 = clint read, 2 = ex write target, 3 = clint write target.
    logic [11:0]     lk_addr [4];
    logic [XLEN-1:0] lk_data [4];
    csr_decode_t     lk_dec  [4];

    assign lk_addr[0] = ex_raddr_i;
    assign lk_addr[1] = clint_raddr_i;
    assign lk_addr[2] = ex_waddr_i;
    assign lk_addr[3] = clint_waddr_i;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lk_dec[i]  = decode_csr(lk_addr[i], HPM_BUILT);
            lk_data[i] = '0;
            case (lk_addr[i])
                CSR_MSTATUS:       lk_data[i] = mstatus_q;
                CSR_MIE:           lk_data[i] = mie_q;
                CSR_MTVEC:         lk_data[i] = mtvec_q;
                CSR_MCOUNTINHIBIT: lk_data[i] = mcountinhibit_q;
                CSR_MSCRATCH:      lk_data[i] = mscratch_q;
                CSR_MEPC:          lk_data[i] = mepc_q;
                CSR_MCAUSE:        lk_data[i] = mcause_q;
                CSR_MIP:           lk_data[i] = mip_q;
                default: begin
                    for (int c = 0; c < NUM_CNT; c++) begin
                        if (lk_dec[i].is_cnt && lk_dec[i].cidx == 5'(c))
                            lk_data[i] = lk_dec[i].hi ? XLEN'(cnt_hi[c]) : XLEN'(cnt_lo[c]);
                    end
                end
            endcase
        end
    end

    logic            ex_wen, ex_wok, cl_wok, cl_own;
    logic [XLEN-1:0] ex_wdata;

    // S/C with a zero operand is a pure read and never counts as a write.
    always_comb begin
        ex_wen = ex_we_i && (csr_op_e'(ex_op_i) != OP_NONE) &&
                 !((csr_op_e'(ex_op_i) == OP_S || csr_op_e'(ex_op_i) == OP_C) &&
                   ex_data_i == '0);
        case (csr_op_e'(ex_op_i))
            OP_S:    ex_wdata = lk_data[2] | ex_data_i;
            OP_C:    ex_wdata = lk_data[2] & ~ex_data_i;
            default: ex_wdata = ex_data_i;
        endcase
        ex_wok = ex_wen && lk_dec[2].impl && !lk_dec[2].ro;
        cl_own = clint_we_i && lk_dec[3].impl && !lk_dec[3].ro;
        cl_wok = cl_own && !(ex_wok && ex_waddr_i == clint_waddr_i);
    end

    assign ex_data_o    = (ex_wok && ex_waddr_i == ex_raddr_i) ? ex_wdata : lk_data[0];
    assign clint_data_o = (cl_own && clint_waddr_i == clint_raddr_i) ? clint_data_i
                                                                      : lk_data[1];
    assign ex_illegal_o = !lk_dec[0].impl ||
                          (ex_wen && (!lk_dec[2].impl || lk_dec[2].ro));

    // Write ports applied in order clint then ex, so ex wins on a shared address.
    logic            wp_en   [2];
    logic [11:0]     wp_addr [2];
    logic [XLEN-1:0] wp_data [2];
    csr_decode_t     wp_dec  [2];

    assign wp_en[0]   = cl_wok;
    assign wp_addr[0] = clint_waddr_i;
    assign wp_data[0] = clint_data_i;
    assign wp_dec[0]  = lk_dec[3];
    assign wp_en[1]   = ex_wok;
    assign wp_addr[1] = ex_waddr_i;
    assign wp_data[1] = ex_wdata;
    assign wp_dec[1]  = lk_dec[2];

    always_comb begin
        mstatus_d       = mstatus_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcause_d        = mcause_q;
        mepc_d          = mepc_q;
        mscratch_d      = mscratch_q;
        mcountinhibit_d = mcountinhibit_q;
        cnt_we_lo       = '0;
        cnt_we_hi       = '0;
        for (int c = 0; c < NUM_CNT; c++) begin
            cnt_wlo[c] = '0;
            cnt_whi[c] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            if (wp_en[p]) begin
                case (wp_addr[p])
                    CSR_MSTATUS:       mstatus_d       = wp_data[p];
                    CSR_MIE:           mie_d           = wp_data[p];
                    CSR_MTVEC:         mtvec_d         = wp_data[p];
                    CSR_MCAUSE:        mcause_d        = wp_data[p];
                    CSR_MEPC:          mepc_d          = wp_data[p];
                    CSR_MSCRATCH:      mscratch_d      = wp_data[p];
                    CSR_MCOUNTINHIBIT: mcountinhibit_d = wp_data[p] & CINH_MASK;
                    default: begin
                        for (int c = 0; c < NUM_CNT; c++) begin
                            if (wp_dec[p].is_cnt && wp_dec[p].cidx == 5'(c)) begin
                                if (wp_dec[p].hi) begin
                                    cnt_we_hi[c] = 1'b1;
                                    cnt_whi[c]   = wp_data[p][31:0];
                                end else begin
                                    cnt_we_lo[c] = 1'b1;
                                    cnt_wlo[c]   = wp_data[p][31:0];
                                end
                            end
                        end
                    end
                endcase
            end
        end
        mip_d           = '0;
        mip_d[MIP_MEIP] = irq_ext_i;
        mip_d[MIP_MTIP] = irq_timer_i;
        mip_d[MIP_MSIP] = irq_sw_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q       <= '0;
            mie_q           <= '0;
            mtvec_q         <= MTVEC_RESET;
            mcause_q        <= '0;
            mepc_q          <= '0;
            mscratch_q      <= '0;
            mcountinhibit_q <= '0;
            mip_q           <= '0;
        end else begin
            mstatus_q       <= mstatus_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcause_q        <= mcause_d;
            mepc_q          <= mepc_d;
            mscratch_q      <= mscratch_d;
            mcountinhibit_q <= mcountinhibit_d;
            mip_q           <= mip_d;
        end
    end

`ifdef CSR_HPM_EN
    assign cnt_inc = {hpm_event_i, instret_i, 1'b1};
    assign cnt_inh = {mcountinhibit_q[3 +: NUM_HPM], mcountinhibit_q[2], mcountinhibit_q[0]};
`else
    logic unused_hpm;
    assign unused_hpm = ^hpm_event_i;
    assign cnt_inc    = {instret_i, 1'b1};
    assign cnt_inh    = {mcountinhibit_q[2], mcountinhibit_q[0]};
`endif

    for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
        csr_counter64 u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (cnt_inc[c]),
            .inhibit_i  (cnt_inh[c]),
            .we_lo_i    (cnt_we_lo[c]),
            .we_hi_i    (cnt_we_hi[c]),
            .wdata_lo_i (cnt_wlo[c]),
            .wdata_hi_i (cnt_whi[c]),
            .lo_o       (cnt_lo[c]),
            .hi_o       (cnt_hi[c])
        );
    end

    assign mtvec_o         = mtvec_q;
    assign mepc_o          = mepc_q;
    assign mstatus_o       = mstatus_q;
    assign global_int_en_o = mstatus_q[MSTATUS_MIE];
    assign irq_pending_o   = mstatus_q[MSTATUS_MIE] & (|(mip_q & mie_q));

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: inputs change just after each falling edge and
// outputs are compared before the next rising edge.
module tb_csr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we_i;
    logic [1:0]  ex_op_i;
    logic [11:0] ex_raddr_i, ex_waddr_i;
    logic [31:0] ex_data_i, ex_data_o;
    logic        ex_illegal_o;
    logic        clint_we_i;
    logic [11:0] clint_raddr_i, clint_waddr_i;
    logic [31:0] clint_data_i, clint_data_o;
    logic        instret_i;
    logic [3:0]  hpm_event_i;
    logic        irq_ext_i, irq_timer_i, irq_sw_i;
    logic [31:0] mtvec_o, mepc_o, mstatus_o;
    logic        global_int_en_o, irq_pending_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csr_bank #(.XLEN(32), .NUM_HPM(4), .MTVEC_RESET(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_we_i         (ex_we_i),
        .ex_op_i         (ex_op_i),
        .ex_raddr_i      (ex_raddr_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_data_i       (ex_data_i),
        .ex_data_o       (ex_data_o),
        .ex_illegal_o    (ex_illegal_o),
        .clint_we_i      (clint_we_i),
        .clint_raddr_i   (clint_raddr_i),
        .clint_waddr_i   (clint_waddr_i),
        .clint_data_i    (clint_data_i),
        .clint_data_o    (clint_data_o),
        .instret_i       (instret_i),
        .hpm_event_i     (hpm_event_i),
        .irq_ext_i       (irq_ext_i),
        .irq_timer_i     (irq_timer_i),
        .irq_sw_i        (irq_sw_i),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .mstatus_o       (mstatus_o),
        .global_int_en_o (global_int_en_o),
        .irq_pending_o   (irq_pending_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic no_writes();
        ex_we_i      = 1'b0;
        ex_op_i      = 2'b00;
        ex_waddr_i   = 12'h000;
        ex_data_i    = '0;
        clint_we_i   = 1'b0;
        clint_waddr_i = 12'h000;
        clint_data_i = '0;
    endtask

    task automatic ex_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        ex_we_i    = 1'b1;
        ex_op_i    = op;
        ex_waddr_i = a;
        ex_data_i  = d;
    endtask

    task automatic clint_write(input logic [11:0] a, input logic [31:0] d);
        clint_we_i    = 1'b1;
        clint_waddr_i = a;
        clint_data_i  = d;
    endtask

    initial begin
        // Reset with a competing mstatus write: reset must win.
        rst = 1'b1;
        no_writes();
        ex_raddr_i = 12'h340; clint_raddr_i = 12'h340;
        instret_i = 1'b0; hpm_event_i = '0;
        irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;
        ex_write(2'b01, 12'h300, 32'h8);
        repeat (2) next_cycle();
        check("rst_mstatus", mstatus_o, 32'h0);
        check("rst_mtvec_o", mtvec_o, 32'h0);
        check("rst_mepc", mepc_o, 32'h0);
        check("rst_mie_en", {31'd0, global_int_en_o}, 32'h0);
        check("rst_pending", {31'd0, irq_pending_o}, 32'h0);

        // Release reset; mcycle counts 0,1,2.
        rst = 1'b0;
        no_writes();
        ex_raddr_i = 12'hB00; clint_raddr_i = 12'h305;
        #1;
        check("mtvec_rd", clint_data_o, 32'h0);
        check("mcycle_0", ex_data_o, 32'd0);
        check("rd_legal", {31'd0, ex_illegal_o}, 32'h0);
        next_cycle();
        check("mcycle_1", ex_data_o, 32'd1);
        next_cycle();
        check("mcycle_2", ex_data_o, 32'd2);

        // mstatus via ex, mie via clint in the same cycle; ex read bypass.
        ex_write(2'b01, 12'h300, 32'h8);
        clint_write(12'h304, 32'h80);
        ex_raddr_i = 12'h300;
        #1;
        check("mstatus_bypass", ex_data_o, 32'h8);
        next_cycle();
        no_writes();
        clint_raddr_i = 12'h304;
        irq_timer_i = 1'b1;
        #1;
        check("mstatus_o", mstatus_o, 32'h8);
        check("mie_rd", clint_data_o, 32'h80);
        check("gie_on", {31'd0, global_int_en_o}, 32'h1);
        check("pending_lat", {31'd0, irq_pending_o}, 32'h0);
        next_cycle();
        ex_raddr_i = 12'h344;
        #1;
        check("pending_on", {31'd0, irq_pending_o}, 32'h1);
        check("mip_rd", ex_data_o, 32'h80);

        // Clear MIE with a C op.
        ex_write(2'b11, 12'h300, 32'h8);
        ex_raddr_i = 12'h300;
        #1;
        check("clr_bypass", ex_data_o, 32'h0);
        next_cycle();
        no_writes();
        #1;
        check("mstatus_clr", mstatus_o, 32'h0);
        check("pending_off", {31'd0, irq_pending_o}, 32'h0);
        irq_timer_i = 1'b0;

        // Same-address collision: ex wins; read bypass returns ex value.
        ex_write(2'b01, 12'h340, 32'hA);
        clint_write(12'h340, 32'hB);
        ex_raddr_i = 12'h340;
        #1;
        check("collide_bypass", ex_data_o, 32'hA);
        next_cycle();
        no_writes();
        clint_raddr_i = 12'h340;
        #1;
        check("collide_commit", clint_data_o, 32'hA);

        // Different addresses both commit; then S op on mscratch.
        ex_write(2'b01, 12'h341, 32'h1234);
        clint_write(12'h342, 32'h55);
        next_cycle();
        no_writes();
        clint_raddr_i = 12'h342;
        #1;
        check("mepc_o", mepc_o, 32'h1234);
        check("mcause_rd", clint_data_o, 32'h55);
        ex_write(2'b10, 12'h340, 32'h5);
        clint_write(12'h305, 32'h8000_0100);
        next_cycle();
        no_writes();
        #1;
        check("mscratch_set", ex_data_o, 32'hF);
        check("mtvec_clint", mtvec_o, 32'h8000_0100);

        // Illegal accesses change nothing.
        ex_write(2'b01, 12'hC00, 32'h1);
        ex_raddr_i = 12'h340;
        #1;
        check("ill_ro_w", {31'd0, ex_illegal_o}, 32'h1);
        ex_write(2'b01, 12'h7FF, 32'h5);
        #1;
        check("ill_unimpl_w", {31'd0, ex_illegal_o}, 32'h1);
        ex_write(2'b10, 12'hC00, 32'h0);
        #1;
        check("ro_set_zero", {31'd0, ex_illegal_o}, 32'h0);
        ex_write(2'b01, 12'h344, 32'hFFFF);
        next_cycle();
        no_writes();
        ex_raddr_i = 12'h344;
        #1;
        check("mip_unchanged", ex_data_o, 32'h0);
        ex_raddr_i = 12'h7FF;
        #1;
        check("ill_rd", {31'd0, ex_illegal_o}, 32'h1);
        check("ill_rd_zero", ex_data_o, 32'h0);

        // mcycle carry across halves, then inhibit.
        ex_write(2'b01, 12'hB00, 32'hFFFF_FFFF);
        clint_write(12'hB80, 32'h0);
        next_cycle();
        no_writes();
        ex_raddr_i = 12'hB00; clint_raddr_i = 12'hB80;
        #1;
        check("cyc_lo_set", ex_data_o, 32'hFFFF_FFFF);
        check("cyc_hi_set", clint_data_o, 32'h0);
        next_cycle();
        check("cyc_lo_wrap", ex_data_o, 32'h0);
        check("cyc_hi_carry", clint_data_o, 32'h1);
        ex_write(2'b01, 12'h320, 32'h1);
        next_cycle();
        no_writes();
        #1;
        check("cyc_last_inc", ex_data_o, 32'h1);
        next_cycle();
        check("cyc_frozen", ex_data_o, 32'h1);
        check("cyc_hi_frozen", clint_data_o, 32'h1);
        ex_write(2'b01, 12'h320, 32'h0);
        next_cycle();
        no_writes();
        #1;
        check("cyc_resume_edge", ex_data_o, 32'h1);
        next_cycle();
        check("cyc_resumed", ex_data_o, 32'h2);

        // A half write suppresses that cycle's increment.
        ex_write(2'b01, 12'hB00, 32'h100);
        #1;
        check("cyc_w_bypass", ex_data_o, 32'h100);
        next_cycle();
        no_writes();
        #1;
        check("cyc_w_noinc", ex_data_o, 32'h100);
        next_cycle();
        check("cyc_w_inc", ex_data_o, 32'h101);

        // minstret through the user alias.
        instret_i = 1'b1;
        repeat (3) next_cycle();
        instret_i = 1'b0;
        ex_raddr_i = 12'hC02; clint_raddr_i = 12'hC82;
        #1;
        check("instret_lo", ex_data_o, 32'd3);
        check("instret_hi", clint_data_o, 32'd0);

        // hpm3 address depends on build.
        ex_raddr_i = 12'hB03;
        hpm_event_i = 4'b0001;
        next_cycle();
        hpm_event_i = 4'b0000;
        #1;
`ifdef CSR_HPM_EN
        check("hpm3_rd", ex_data_o, 32'd1);
        check("hpm3_legal", {31'd0, ex_illegal_o}, 32'h0);
`else
        check("hpm3_rd", ex_data_o, 32'd0);
        check("hpm3_illegal", {31'd0, ex_illegal_o}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
